// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: samples the 1 Hz divider toggle as data, turns each rising edge
// into a one-cycle tick and steps one of four LED patterns. Optional dimming: LED_PWM_DIM_EN.
module led_pattern_sequencer #(
    parameter int N_LEDS = 8
`ifdef LED_PWM_DIM_EN
    ,
    parameter int unsigned DIM_DUTY = 64
`endif
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              clk_1hz,
    input  logic [1:0]        mode,
    input  logic              pause,
    output logic [N_LEDS-1:0] led,
    output logic              tick
);

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [N_LEDS-1:0] LSB_ONLY = {{(N_LEDS-1){1'b0}}, 1'b1};

    logic              sync1_q;
    logic              sync2_q;
    logic              prev_q;
    mode_e             mode_in;
    mode_e             mode_q;
    dir_e              dir_q;
    dir_e              dir_d;
    logic [N_LEDS-1:0] pattern_q;
    logic [N_LEDS-1:0] adv_d;
    logic [N_LEDS-1:0] init_d;

    // clk_1hz is asynchronous; two flops before it is trusted, a third for the edge
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= clk_1hz;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick    = sync2_q & ~prev_q;
    assign mode_in = mode_e'(mode);

    always_comb begin
        init_d = '0;
        if (mode_in == MODE_CHASE || mode_in == MODE_BOUNCE) begin
            init_d = LSB_ONLY;
        end
    end

    always_comb begin
        adv_d = pattern_q;
        dir_d = dir_q;
        case (mode_q)
            MODE_BLINK: adv_d = ~pattern_q;
            MODE_CHASE: adv_d = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
            MODE_BOUNCE: begin
                // direction flips on arrival at an end bit, so ends never repeat
                if (dir_q == DIR_UP) begin
                    adv_d = pattern_q << 1;
                    if (adv_d[N_LEDS-1]) dir_d = DIR_DOWN;
                end else begin
                    adv_d = pattern_q >> 1;
                    if (adv_d[0]) dir_d = DIR_UP;
                end
            end
            MODE_COUNT: adv_d = pattern_q + LSB_ONLY;
            default:    adv_d = pattern_q;
        endcase
    end

    // a mode change outranks a coincident tick; paused ticks are simply dropped
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_BLINK;
            pattern_q <= '0;
            dir_q     <= DIR_UP;
        end else begin
            mode_q <= mode_in;
            if (mode_in != mode_q) begin
                pattern_q <= init_d;
                dir_q     <= DIR_UP;
            end else if (tick && !pause) begin
                pattern_q <= adv_d;
                dir_q     <= dir_d;
            end
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [7:0] pwm_cnt_q;
    logic       pwm_on_q;

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= 8'd0;
            pwm_on_q  <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            pwm_on_q  <= (32'(pwm_cnt_q) < DIM_DUTY);
        end
    end

    assign led = pattern_q & {N_LEDS{pwm_on_q}};
`else
    assign led = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (N_LEDS = 8): table-driven pattern steps
// with a queue scoreboard, plus hand-written collision, pause, reset and dimming sequences.
module tb_led_pattern_sequencer;

    typedef struct {
        logic [1:0] mode;
        logic       pause;
        logic [7:0] exp_led;
    } vec_t;

`ifdef LED_PWM_DIM_EN
    localparam int EXP_ON = 64;
`else
    localparam int EXP_ON = 256;
`endif

    logic       i_clk;
    logic       reset;
    logic       clk_1hz;
    logic [1:0] mode;
    logic       pause;
    logic [7:0] led;
    logic       tick;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_cmp;
    int         n_err;
    int         ticks_seen;

    led_pattern_sequencer #(.N_LEDS(8)) dut (
        .i_clk   (i_clk),
        .reset   (reset),
        .clk_1hz (clk_1hz),
        .mode    (mode),
        .pause   (pause),
        .led     (led),
        .tick    (tick)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] init_of(input logic [1:0] m);
        return (m == 2'd1 || m == 2'd2) ? 8'h01 : 8'h00;
    endfunction

    function automatic void add_vec(input logic [1:0] m, input logic p, input logic [7:0] e);
        vec_t v;
        v.mode = m;
        v.pause = p;
        v.exp_led = e;
        vecs.push_back(v);
    endfunction

    // one clk_1hz rising edge: tick two negedges later, one cycle wide, led updated after
    task automatic do_tick(input logic [7:0] exp_led, input string nm, input bit chk_led);
        int         waited;
        int         extra;
        logic [7:0] e;
        exp_q.push_back(exp_led);
        @(negedge i_clk);
        clk_1hz = 1'b1;
        waited = 0;
        do begin
            @(negedge i_clk);
            waited++;
        end while (!tick && waited < 8);
        check({nm, " tick latency"}, waited, 2);
        if (tick) ticks_seen++;
        @(negedge i_clk);
        check({nm, " tick width"}, {31'd0, tick}, 0);
        e = exp_q.pop_front();
        if (chk_led) check({nm, " led"}, {24'd0, led}, {24'd0, e});
        clk_1hz = 1'b0;
        extra = 0;
        repeat (4) begin
            @(negedge i_clk);
            if (tick) extra++;
        end
        check({nm, " no tick on fall"}, extra, 0);
    endtask

    task automatic set_mode(input logic [1:0] m, input string nm);
        mode = m;
        repeat (2) @(negedge i_clk);
        check({nm, " load"}, {24'd0, led}, {24'd0, init_of(m)});
    endtask

    initial begin
        logic [1:0] cur_mode;
        int         on_cnt;
        logic [7:0] e;
        n_cmp = 0;
        n_err = 0;
        ticks_seen = 0;
        reset = 1'b1;
        mode = 2'd0;
        pause = 1'b0;
        clk_1hz = 1'b0;

        add_vec(2'd0, 1'b0, 8'hFF);
        add_vec(2'd0, 1'b0, 8'h00);
        foreach (vecs[i]) begin end
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] c;
            c = 8'h01;
            add_vec(2'd1, 1'b0, c << (i % 8));
        end
        add_vec(2'd2, 1'b0, 8'h02);
        add_vec(2'd2, 1'b0, 8'h04);
        add_vec(2'd2, 1'b0, 8'h08);
        add_vec(2'd2, 1'b0, 8'h10);
        add_vec(2'd2, 1'b0, 8'h20);
        add_vec(2'd2, 1'b0, 8'h40);
        add_vec(2'd2, 1'b0, 8'h80);
        add_vec(2'd2, 1'b1, 8'h80);
        add_vec(2'd2, 1'b0, 8'h40);
        add_vec(2'd2, 1'b0, 8'h20);
        add_vec(2'd2, 1'b0, 8'h10);
        add_vec(2'd2, 1'b0, 8'h08);
        add_vec(2'd2, 1'b0, 8'h04);
        add_vec(2'd2, 1'b0, 8'h02);
        add_vec(2'd2, 1'b0, 8'h01);
        add_vec(2'd2, 1'b0, 8'h02);
        add_vec(2'd2, 1'b0, 8'h04);

        repeat (3) @(negedge i_clk);
        check("reset led", {24'd0, led}, 0);
        check("reset tick", {31'd0, tick}, 0);
        reset = 1'b0;
        repeat (3) @(negedge i_clk);
        check("post-release led", {24'd0, led}, 0);
        check("post-release tick", {31'd0, tick}, 0);

`ifndef LED_PWM_DIM_EN
        cur_mode = 2'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].mode != cur_mode) begin
                cur_mode = vecs[i].mode;
                set_mode(cur_mode, $sformatf("vec%0d mode%0d", i, cur_mode));
            end
            pause = vecs[i].pause;
            do_tick(vecs[i].exp_led, $sformatf("vec%0d", i), 1'b1);
        end
        pause = 1'b0;

        set_mode(2'd3, "count");
        for (int i = 1; i <= 255; i++) begin
            e = 8'(i);
            do_tick(e, $sformatf("count %0d", i), 1'b1);
        end
        do_tick(8'h00, "count wrap", 1'b1);

        pause = 1'b1;
        ticks_seen = 0;
        for (int i = 0; i < 3; i++) do_tick(8'h00, $sformatf("paused %0d", i), 1'b1);
        check("paused tick count", ticks_seen, 3);
        set_mode(2'd1, "mode change in pause");
        set_mode(2'd3, "back to count in pause");
        pause = 1'b0;

        do_tick(8'h01, "pre-collision 1", 1'b1);
        do_tick(8'h02, "pre-collision 2", 1'b1);
        exp_q.push_back(8'h01);
        @(negedge i_clk);
        clk_1hz = 1'b1;
        repeat (2) @(negedge i_clk);
        check("collision tick present", {31'd0, tick}, 1);
        mode = 2'd1;
        @(negedge i_clk);
        e = exp_q.pop_front();
        check("collision led", {24'd0, led}, {24'd0, e});
        clk_1hz = 1'b0;
        repeat (4) @(negedge i_clk);
        do_tick(8'h02, "after collision", 1'b1);

        set_mode(2'd2, "bounce again");
        do_tick(8'h02, "bounce pre-reset 1", 1'b1);
        do_tick(8'h04, "bounce pre-reset 2", 1'b1);
        @(posedge i_clk);
        #2;
        reset = 1'b1;
        #1;
        check("async reset led", {24'd0, led}, 0);
        check("async reset tick", {31'd0, tick}, 0);
        @(negedge i_clk);
        reset = 1'b0;
        repeat (2) @(negedge i_clk);
        check("reload after reset", {24'd0, led}, 8'h01);

        set_mode(2'd0, "blink for window");
        do_tick(8'hFF, "window setup", 1'b1);
`else
        do_tick(8'hFF, "window setup", 1'b0);
`endif

        on_cnt = 0;
        repeat (256) begin
            @(negedge i_clk);
            if (led == 8'hFF) on_cnt++;
        end
        check("on cycles in 256", on_cnt, EXP_ON);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
